// File: rtl/i2c_master.sv
// i2c_master: single-clock I2C bus master (START, addr+R/W, data bytes, ACK/NACK, STOP).
// Optional feature macro: I2C_MASTER_ARB_CHECK_EN (SDA readback arbitration check).
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_addr, cmd_read, cmd_len latched on accept
//   wr_data/wr_req        write byte stream; wr_req pulses when wr_data is latched
//   rd_data/rd_valid      read byte stream; rd_valid pulses with each received byte
//   busy, done            transfer in progress / 1-clk pulse at end of transfer
//   ack_err, arb_lost     sticky NACK and arbitration-lost flags, cleared on accept
//   SCL                   push-pull bus clock, idles high
//   SDA                   open-drain data line, driven low or released
module i2c_master #(
    parameter int QDIV  = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_addr,
    input  logic             cmd_read,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       wr_data,
    output logic             wr_req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             ack_err,
    output logic             arb_lost,
    output logic             SCL,
    inout  wire              SDA
);
    typedef enum logic [3:0] {IDLE, START, ADDR, AACK, WBYTE, WACK, RBYTE, RACK, STOP} state_t;

    localparam logic [7:0] QMAX = 8'(QDIV - 1);

    state_t           state, next;
    logic [7:0]       qcnt;
    logic [1:0]       q;
    logic [2:0]       bitn;
    logic [7:0]       abyte, dbyte;
    logic [LEN_W-1:0] cnt;
    logic             rd;
    logic [6:0]       rsh;
    logic             sda_low, sda_in, tick, slot_end, last, arb;

    assign SDA       = sda_low ? 1'b0 : 1'bz;
    assign sda_in    = SDA;
    assign tick      = qcnt == QMAX;
    // START is a 3-tick slot; every other state uses full 4-tick slots
    assign slot_end  = tick && q == (state == START ? 2'd2 : 2'd3);
    assign last      = cnt == LEN_W'(1);
    assign busy      = state != IDLE;
    assign cmd_ready = state == IDLE;

`ifdef I2C_MASTER_ARB_CHECK_EN
    // bus reads low while this master is releasing a 1 bit: another master owns the bus
    assign arb = ((state == ADDR && abyte[~bitn]) || (state == WBYTE && dbyte[~bitn])) && !sda_in;
`else
    assign arb = 1'b0;
`endif

    always_comb begin
        next   = state;
        wr_req = 1'b0;
        done   = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                next   = START;
                wr_req = !cmd_read;
            end
            START: if (slot_end) next = ADDR;
            ADDR: if (slot_end) begin
                next = arb ? IDLE : (bitn == 3'd7 ? AACK : ADDR);
                done = arb;
            end
            AACK: if (slot_end) next = sda_in ? STOP : (rd ? RBYTE : WBYTE);
            WBYTE: if (slot_end) begin
                next = arb ? IDLE : (bitn == 3'd7 ? WACK : WBYTE);
                done = arb;
            end
            WACK: if (slot_end) begin
                next   = (sda_in || last) ? STOP : WBYTE;
                wr_req = !sda_in && !last;
            end
            RBYTE: if (slot_end && bitn == 3'd7) next = RACK;
            RACK: if (slot_end) next = last ? STOP : RBYTE;
            STOP: if (slot_end) begin
                next = IDLE;
                done = 1'b1;
            end
            default: next = IDLE;
        endcase
    end

    always_comb begin
        SCL     = (state == IDLE || state == START) ? 1'b1 : state == STOP ? q != 2'd0 : q[1];
        sda_low = state == START ? q != 2'd0 :
                  state == ADDR  ? !abyte[~bitn] :
                  state == WBYTE ? !dbyte[~bitn] :
                  state == RACK  ? !last :
                  state == STOP  ? !q[1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            qcnt     <= '0;
            q        <= '0;
            bitn     <= '0;
            abyte    <= '0;
            dbyte    <= '0;
            cnt      <= '0;
            rd       <= 1'b0;
            rsh      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            ack_err  <= 1'b0;
            arb_lost <= 1'b0;
        end else begin
            state    <= next;
            rd_valid <= 1'b0;
            if (state == IDLE) begin
                qcnt <= '0;
                q    <= '0;
                bitn <= '0;
            end else begin
                qcnt <= tick ? 8'd0 : qcnt + 8'd1;
                if (tick) q <= slot_end ? 2'd0 : q + 2'd1;
                if (slot_end) bitn <= next == state ? bitn + 3'd1 : 3'd0;
            end
            if (state == IDLE && cmd_valid) begin
                abyte    <= {cmd_addr, !cmd_read};
                rd       <= cmd_read;
                cnt      <= cmd_len == '0 ? LEN_W'(1) : cmd_len;
                ack_err  <= 1'b0;
                arb_lost <= 1'b0;
            end
            if (wr_req) dbyte <= wr_data;
            if (slot_end && (state == WACK || state == RACK)) cnt <= cnt - LEN_W'(1);
            if (slot_end && (state == AACK || state == WACK) && sda_in) ack_err <= 1'b1;
            if (slot_end && state == RBYTE) begin
                rsh <= {rsh[5:0], sda_in};
                if (bitn == 3'd7) begin
                    rd_data  <= {rsh, sda_in};
                    rd_valid <= 1'b1;
                end
            end
            if (slot_end && arb) arb_lost <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: self-checking bench for i2c_master with a behavioural I2C slave on the bus.
module tb_i2c_master;
    logic       clk, reset, cmd_valid, cmd_ready, cmd_read;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_len, wr_data, rd_data;
    logic       wr_req, rd_valid, busy, done, ack_err, arb_lost, SCL;
    wire        SDA;

    logic       slave_low = 1'b0, arb_low = 1'b0, sda_b;
    logic [6:0] slv_addr = 7'h2A;
    logic       slv_en = 1'b1;
    int         nack_at = 99;
    logic [7:0] rbytes[0:15];
    logic [7:0] warr[0:1023];
    logic [7:0] pat[0:3];
    int         widx = 0, done_cnt = 0, errors = 0, checks = 0;
    logic [7:0] rq[$];

    // slave-side bus state
    logic       pscl = 1'b1, psda = 1'b1, active = 1'b0, halt = 1'b0;
    logic       bits[$];
    logic [7:0] abyte_s = '0;
    int         bitpos = 0, starts = 0, stops = 0;

    i2c_master #(.QDIV(2), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_read(cmd_read), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .ack_err(ack_err), .arb_lost(arb_lost),
        .SCL(SCL), .SDA(SDA)
    );

    pullup (SDA);
    assign SDA     = (slave_low || arb_low) ? 1'b0 : 1'bz;
    assign sda_b   = (SDA === 1'b0) ? 1'b0 : 1'b1;
    assign wr_data = warr[widx];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (wr_req) widx <= widx + 1;

    always @(negedge clk) begin
        if (rd_valid) rq.push_back(rd_data);
        if (done) done_cnt <= done_cnt + 1;
    end

    // what the slave drives for bus bit number pos of the current frame
    function automatic logic drive_low(input int pos);
        int g, b;
        g = pos % 9;
        b = pos / 9;
        if (b == 0) return g == 8 && slv_en && abyte_s[7:1] == slv_addr;
        if (bits[8]) return 1'b0;
        if (abyte_s[0]) return g == 8 && b - 1 != nack_at;
        return !halt && g < 8 && !rbytes[b-1][7-g];
    endfunction

    // behavioural slave, sampled mid-cycle so simultaneous SCL/SDA moves never look like START/STOP
    always @(negedge clk) begin
        pscl <= SCL;
        psda <= sda_b;
        if (reset) begin
            active    <= 1'b0;
            slave_low <= 1'b0;
        end else if (pscl && SCL && psda && !sda_b) begin
            starts    <= starts + 1;
            active    <= 1'b1;
            bitpos    <= 0;
            halt      <= 1'b0;
            slave_low <= 1'b0;
            bits.delete();
        end else if (pscl && SCL && !psda && sda_b && active) begin
            stops     <= stops + 1;
            active    <= 1'b0;
            slave_low <= 1'b0;
        end else if (active && !pscl && SCL) begin
            bits.push_back(sda_b);
            bitpos <= bitpos + 1;
            if (bitpos < 8) abyte_s <= {abyte_s[6:0], sda_b};
            if (bitpos >= 17 && bitpos % 9 == 8 && !abyte_s[0] && sda_b) halt <= 1'b1;
        end else if (active && pscl && !SCL) begin
            slave_low <= drive_low(bitpos);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready;
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        chk("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 5000 && done_cnt == base; i++) @(negedge clk);
        chk("done_pulse", done_cnt - base, 1);
    endtask

    // one complete transfer checked against the protocol-level model
    task automatic xfer(input logic [6:0] addr, input logic rd_op, input int len, input int nk);
        int n, m, base_w, base_d, base_s, base_p, base_r;
        logic match, err;
        logic [7:0] b;
        n = (len == 0) ? 1 : len;
        match = slv_en && addr == slv_addr;
        nack_at = nk;
        wait_ready;
        base_w = widx; base_d = done_cnt; base_s = stops; base_p = starts; base_r = rq.size();
        for (int i = 0; i < n; i++) begin
            warr[base_w + i] = pat[i];
            rbytes[i] = pat[i];
        end
        cmd_addr = addr; cmd_read = rd_op; cmd_len = 8'(len); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ack_err_cleared", ack_err, 0);
        wait_done(base_d);
        @(negedge clk);
        @(negedge clk);
        m = !match ? 0 : (rd_op ? n : (nk < n ? nk + 1 : n));
        err = !match || (!rd_op && nk < n);
        chk("wr_req_count", widx - base_w, rd_op ? 0 : (match ? m : 1));
        chk("rd_valid_count", rq.size() - base_r, rd_op ? m : 0);
        if (rd_op) for (int i = 0; i < m && base_r + i < rq.size(); i++) chk("rd_byte", rq[base_r + i], pat[i]);
        chk("ack_err", ack_err, err);
        chk("start_count", starts - base_p, 1);
        chk("stop_count", stops - base_s, 1);
        chk("bus_bit_count", bits.size(), 9 * (1 + m) + 1);
        if (bits.size() == 9 * (1 + m) + 1) begin
            b = '0;
            for (int i = 0; i < 8; i++) b = {b[6:0], bits[i]};
            chk("addr_byte", b, {addr, !rd_op});
            chk("addr_ack_bit", bits[8], !match);
            for (int k = 0; k < m; k++) begin
                b = '0;
                for (int i = 0; i < 8; i++) b = {b[6:0], bits[9 + 9 * k + i]};
                if (!rd_op) chk("wr_byte_on_bus", b, pat[k]);
                chk("data_ack_bit", bits[17 + 9 * k], rd_op ? (k == n - 1) : (k == nk));
            end
        end
        chk("idle_busy", busy, 0);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_scl", SCL, 1);
        chk("idle_sda", sda_b, 1);
        chk("arb_lost_clear", arb_lost, 0);
    endtask

    initial begin
        int base_d, base_s, base_p;
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_read = 1'b0; cmd_len = '0;
        for (int i = 0; i < 1024; i++) warr[i] = '0;
        for (int i = 0; i < 16; i++) rbytes[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_scl", SCL, 1);
        chk("rst_sda", sda_b, 1);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_arb_lost", arb_lost, 0);
        reset = 1'b0;
        @(negedge clk);

        pat[0] = 8'hA5;
        xfer(7'h2A, 1'b0, 1, 99);
        pat[0] = 8'h3C; pat[1] = 8'hF0;
        xfer(7'h2A, 1'b1, 2, 99);
        pat[0] = 8'h5A;
        xfer(7'h11, 1'b0, 1, 99);
        xfer(7'h11, 1'b1, 2, 99);
        pat[0] = 8'h81;
        xfer(7'h2A, 1'b0, 0, 99);
        pat[0] = 8'h12; pat[1] = 8'h34; pat[2] = 8'h56;
        xfer(7'h2A, 1'b0, 3, 1);

        // reset in the middle of a write data byte
        wait_ready;
        warr[widx] = 8'hC3; warr[widx + 1] = 8'h3C; nack_at = 99;
        cmd_addr = 7'h2A; cmd_read = 1'b0; cmd_len = 8'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2000 && bitpos < 14; i++) @(negedge clk);
        chk("reached_wbyte", bitpos >= 14, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_scl", SCL, 1);
        chk("midrst_sda", sda_b, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 4; i++) pat[i] = 8'($urandom);
            xfer(($urandom_range(0, 3) != 0) ? 7'h2A : 7'($urandom_range(0, 41)), 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 4));
        end

`ifdef I2C_MASTER_ARB_CHECK_EN
        slv_en = 1'b0;
        wait_ready;
        base_d = done_cnt; base_s = stops; base_p = starts;
        cmd_addr = 7'h55; cmd_read = 1'b0; cmd_len = 8'd1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 200 && starts == base_p; i++) @(negedge clk);
        chk("arb_start_seen", starts - base_p, 1);
        arb_low = 1'b1;
        wait_done(base_d);
        @(negedge clk);
        chk("arb_lost_set", arb_lost, 1);
        chk("arb_busy", busy, 0);
        chk("arb_scl", SCL, 1);
        chk("arb_no_stop", stops - base_s, 0);
        arb_low = 1'b0;
        @(negedge clk);
        chk("arb_sda_released", sda_b, 1);
        chk("arb_ready", cmd_ready, 1);
        slv_en = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Synchronous, single-clock I2C bus master that generates SCL and drives the shared open-drain SDA line.
- Sits directly upstream of the team's I2C slave on the same two-wire bus.
- Accepts one command per transfer: 7-bit address, direction, and a byte count. Streams write data in and read data out over simple valid/req strobes.
- Produces START, address+R/W, data bytes, ACK/NACK handling and STOP.

Parameters:
- QDIV, 4, clk cycles per quarter SCL period (SCL period = 4*QDIV clk cycles); legal range 1..255.
- LEN_W, 8, width of cmd_len.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high in IDLE only; command accepted when cmd_valid && cmd_ready
- cmd_addr  input  7  slave address
- cmd_read  input  1  1 = master reads, 0 = master writes
- cmd_len  input  LEN_W  byte count; 0 is treated as 1
- wr_data  input  8  write byte; must be valid when wr_req pulses
- wr_req  output  1  1-clk pulse: master has latched wr_data for the next byte
- rd_data  output  8  received byte
- rd_valid  output  1  1-clk pulse, rd_data valid
- busy  output  1  transfer in progress (START through STOP)
- done  output  1  1-clk pulse when STOP completes
- ack_err  output  1  sticky NACK flag; cleared on next command accept
- arb_lost  output  1  sticky arbitration-lost flag (see optional feature)
- SCL  output  1  bus clock, push-pull, idles 1
- SDA  inout  1  open-drain: driven 0 or released to 'z', never driven 1

Behaviour:
- Reset values:
  - SCL=1, SDA released, cmd_ready=1, busy=0.
  - wr_req=0, rd_valid=0, done=0, rd_data=0, ack_err=0, arb_lost=0.
  - State=IDLE, all counters 0.
- Reset mid-transfer aborts immediately to IDLE. No STOP is generated. Reset dominates all other events.
- Quarter tick: counter 0..QDIV-1; a tick fires when the counter wraps. Each bit slot is 4 ticks, q0..q3:
  - q0: SCL=0; change SDA here.
  - q1: SCL=0.
  - q2: SCL=1.
  - q3: SCL=1; sample SDA at the end of q3.
- States:
  - IDLE: on accept, latch addr/read/len and clear flags. If writing, pulse wr_req and latch wr_data in the same cycle. Go to START.
  - START: SCL=1, then SDA released for 1 tick, then SDA=0 for 2 ticks. Go to ADDR.
  - ADDR: 8 bit slots, MSB first: addr[6:0], then R/W bit. The wire R/W bit is 0 for a read and 1 for a write (bus convention of the slave). Go to AACK.
  - AACK: release SDA and sample in the 9th slot.
    - Sampled 1 (NACK): ack_err=1, go to STOP.
    - Otherwise go to WBYTE or RBYTE.
  - WBYTE: shift out the latched byte MSB first over 8 slots. Go to WACK.
  - WACK: sample in the 9th slot.
    - NACK: ack_err=1, go to STOP.
    - ACK and bytes remain: pulse wr_req in the q3 cycle, latch wr_data, go to WBYTE.
    - ACK and none remain: go to STOP.
  - RBYTE: release SDA for 8 slots and shift samples in. At the end of the 8th slot, pulse rd_valid with rd_data.
  - RACK: drive SDA=0 (ACK) if bytes remain; release (NACK) on the last byte.
    - Bytes remain: go to RBYTE.
    - Last byte: go to STOP.
  - STOP: SCL=0 with SDA=0 for 1 tick, SCL=1 for 1 tick, then release SDA with SCL=1 for 2 ticks. Pulse done, go to IDLE.
- cmd_valid is ignored while busy. A new command may be accepted the cycle after done.
- Byte counter decrements after each data ACK slot. Counter value 1 marks the last byte.

Optional Feature:
- Macro I2C_MASTER_ARB_CHECK_EN.
- Defined:
  - In ADDR and WBYTE q3 slots where the master releases SDA, a sampled 0 sets arb_lost=1.
  - The master then releases SDA, holds SCL=1, and returns to IDLE with a done pulse. No STOP is generated.
- Undefined: no readback check; arb_lost is tied to 0.

Test Plan:
- Write with QDIV=2, addr=0x2A, len=1, wr_data=0xA5, slave ACKs all:
  - SDA shows bits 0101010 then R/W bit 1.
  - Then 10100101 follows.
  - Exactly 1 wr_req, done after STOP, ack_err=0.
- Read with addr=0x2A, len=2, slave returns 0x3C, 0xF0:
  - Two rd_valid pulses with 0x3C then 0xF0.
  - Master ACKs byte 1 and NACKs byte 2; STOP follows.
- No slave at addr=0x11:
  - Address NACK gives ack_err=1 and STOP.
  - No wr_req beyond the first, no rd_valid.
  - ack_err clears on the next accept.
- len=0 write: behaves as len=1, exactly 1 data byte on the bus.
- Reset asserted during WBYTE bit 4: next clk shows SCL=1, SDA='z', busy=0, cmd_ready=1.
- With I2C_MASTER_ARB_CHECK_EN, force SDA=0 during address bit 6 (a 1 bit): arb_lost=1, returns to IDLE, no STOP, SDA released.
